vga_plot_receiver: RTL and testbench



---
 rtl/vga_pkg.sv | 44 ++++
 rtl/framebuffer_ram.sv | 30 +++
 rtl/vga_plot_receiver.sv | 185 ++++++++++++++++++
 tb/tb_vga_plot_receiver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants, state encoding and address helper for the VGA plot receiver.
package vga_pkg;

    // Framebuffer geometry and background colour
    localparam int XRES = 320;
    localparam int YRES = 240;
    localparam logic [5:0] BG_COLOUR = 6'b000000;

    // Horizontal timing in pixel ticks
    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines
    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // Framebuffer storage
    localparam int FB_DEPTH = XRES * YRES;
    localparam int ADDR_W   = 17;

    // Colour fields: 2 bits per channel stored, 8 bits per channel driven out
    localparam int CHAN_W     = 2;
    localparam int COLOUR_W   = 3 * CHAN_W;
    localparam int VGA_CHAN_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } clear_state_t;

    // Row-major address for a 320-wide framebuffer: y*320 + x built from shifts
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] y, input logic [8:0] x);
        logic [ADDR_W-1:0] y_wide;
        y_wide = {9'b0, y};
        return (y_wide << 8) + (y_wide << 6) + {8'b0, x};
    endfunction

endpackage

// File: rtl/framebuffer_ram.sv
// Simple dual-port framebuffer: one synchronous write port, one registered
// read port that returns the old contents on a same-address collision.
module framebuffer_ram
    import vga_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int AW    = ADDR_W,
    parameter int DW    = COLOUR_W
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int IW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    // Read samples the array before this edge's write lands (read-before-write)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[IW-1:0]] <= wr_data;
        end
        rd_data <= mem[rd_addr[IW-1:0]];
    end

endmodule

// File: rtl/vga_plot_receiver.sv
// Pixel-plot receiver: stores plots in a 320-wide framebuffer, clears it to the
// background colour after reset, and scans it out as VGA with 2x2 pixels.
module vga_plot_receiver #(
    parameter int          YRES      = vga_pkg::YRES,
    parameter logic [5:0]  BG_COLOUR = vga_pkg::BG_COLOUR,
    parameter int          H_VIS     = vga_pkg::H_VIS,
    parameter int          H_FP      = vga_pkg::H_FP,
    parameter int          H_SYNC    = vga_pkg::H_SYNC,
    parameter int          H_BP      = vga_pkg::H_BP,
    parameter int          V_VIS     = vga_pkg::V_VIS,
    parameter int          V_FP      = vga_pkg::V_FP,
    parameter int          V_SYNC    = vga_pkg::V_SYNC,
    parameter int          V_BP      = vga_pkg::V_BP
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [8:0] xIn,
    input  logic [7:0] yIn,
    input  logic [5:0] colourIn,
    input  logic       plotIn,
    output logic       busy,
    output logic [7:0] dropCount,
    output logic       vgaClk,
    output logic [7:0] vgaR,
    output logic [7:0] vgaG,
    output logic [7:0] vgaB,
    output logic       vgaHS,
    output logic       vgaVS,
    output logic       vgaBlankN,
    output logic       frameStart
);

    import vga_pkg::*;

    localparam int DEPTH = XRES * YRES;

    localparam logic [9:0]        H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]        V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]        H_VIS_L  = 10'(H_VIS);
    localparam logic [9:0]        V_VIS_L  = 10'(V_VIS);
    localparam logic [9:0]        HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0]        HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]        VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0]        VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [8:0]        X_LIMIT  = 9'(XRES);
    localparam logic [7:0]        Y_LIMIT  = 8'(YRES);

    logic                pix_en;
    logic [9:0]          h_count;
    logic [9:0]          v_count;
    logic                scan_visible;
    logic                hs_active;
    logic                vs_active;
    logic [ADDR_W-1:0]   rd_addr;
    logic [COLOUR_W-1:0] rd_data;

    clear_state_t        state;
    clear_state_t        state_next;
    logic [ADDR_W-1:0]   clr_addr;
    logic [ADDR_W-1:0]   clr_addr_next;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [COLOUR_W-1:0] wr_data;
    logic                plot_drop;
    logic                plot_in_range;

    assign vgaClk = pix_en;
    assign busy   = (state == CLEAR);

    // Pixel tick divides Clock by two; scan counters step once per tick
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pix_en  <= 1'b0;
            h_count <= '0;
            v_count <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                if (h_count == H_LAST) begin
                    h_count <= '0;
                    v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
                end else begin
                    h_count <= h_count + 10'd1;
                end
            end
        end
    end

    // Scan windows and the framebuffer address of the 2x2 block under the beam
    always_comb begin
        scan_visible = (h_count < H_VIS_L) && (v_count < V_VIS_L);
        hs_active    = (h_count >= HS_START) && (h_count < HS_END);
        vs_active    = (v_count >= VS_START) && (v_count < VS_END);
        rd_addr      = scan_visible ? pix_addr(v_count[8:1], h_count[9:1]) : '0;
    end

    // Clear sequencer state register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    // Write-port arbitration: the clear sweep owns the port until it finishes
    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        plot_in_range = (xIn < X_LIMIT) && (yIn < Y_LIMIT);
        wr_en         = 1'b0;
        wr_addr       = pix_addr(yIn, xIn);
        wr_data       = colourIn;
        plot_drop     = 1'b0;
        case (state)
            CLEAR: begin
                wr_en         = 1'b1;
                wr_addr       = clr_addr;
                wr_data       = BG_COLOUR;
                clr_addr_next = clr_addr + 1'b1;
                plot_drop     = plotIn;
                if (clr_addr == CLR_LAST) begin
                    state_next    = RUN;
                    clr_addr_next = '0;
                end
            end
            RUN: begin
                if (plotIn) begin
                    wr_en     = plot_in_range;
                    plot_drop = ~plot_in_range;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // Saturating count of plots that never reached the framebuffer
    always_ff @(posedge Clock) begin
        if (Reset) begin
            dropCount <= '0;
        end else if (plot_drop && (dropCount != 8'hFF)) begin
            dropCount <= dropCount + 8'd1;
        end
    end

    framebuffer_ram #(
        .DEPTH (DEPTH),
        .AW    (ADDR_W),
        .DW    (COLOUR_W)
    ) u_framebuffer (
        .clk     (Clock),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Output stage: one tick behind the counters so colour and sync stay aligned
    always_ff @(posedge Clock) begin
        if (Reset) begin
            vgaR       <= '0;
            vgaG       <= '0;
            vgaB       <= '0;
            vgaHS      <= 1'b1;
            vgaVS      <= 1'b1;
            vgaBlankN  <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            frameStart <= pix_en && (h_count == '0) && (v_count == '0);
            if (pix_en) begin
                vgaHS     <= ~hs_active;
                vgaVS     <= ~vs_active;
                vgaBlankN <= scan_visible;
                vgaR      <= scan_visible ? {4{rd_data[5:4]}} : '0;
                vgaG      <= scan_visible ? {4{rd_data[3:2]}} : '0;
                vgaB      <= scan_visible ? {4{rd_data[1:0]}} : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_plot_receiver.sv
// Directed bench for vga_plot_receiver, run with a short framebuffer (4 rows)
// and a short vertical timing (12 lines) so whole frames fit in a quick run.
// Horizontal timing and the 320-pixel row width are the real ones.
module tb_vga_plot_receiver;

    localparam int YRES_TB   = 4;
    localparam int V_VIS_TB  = 8;
    localparam int V_FP_TB   = 1;
    localparam int V_SYNC_TB = 2;
    localparam int V_BP_TB   = 1;
    localparam int H_TOT     = 800;
    localparam int V_TOT     = V_VIS_TB + V_FP_TB + V_SYNC_TB + V_BP_TB;
    localparam int FRAME_CYC = 2 * H_TOT * V_TOT;
    localparam int CLEAR_CYC = 320 * YRES_TB;
    localparam int NPROBE    = 17;

    // Probe pixels in VGA coordinates checked in both monitored frames
    localparam int PROBE_H [NPROBE] = '{10, 11, 10, 11, 9, 12, 10, 638, 639, 637, 0, 1, 20, 21, 20, 19, 22};
    localparam int PROBE_V [NPROBE] = '{ 6,  6,  7,  7, 6,  6,  5,   6,   7,   6, 2, 3,  2,  2,  3,  2,  2};

    logic       Clock;
    logic       Reset;
    logic [8:0] xIn;
    logic [7:0] yIn;
    logic [5:0] colourIn;
    logic       plotIn;
    logic       busy;
    logic [7:0] dropCount;
    logic       vgaClk;
    logic [7:0] vgaR;
    logic [7:0] vgaG;
    logic [7:0] vgaB;
    logic       vgaHS;
    logic       vgaVS;
    logic       vgaBlankN;
    logic       frameStart;

    int assertCount = 0;
    int failCount   = 0;
    int n;

    vga_plot_receiver #(
        .YRES   (YRES_TB),
        .V_VIS  (V_VIS_TB),
        .V_FP   (V_FP_TB),
        .V_SYNC (V_SYNC_TB),
        .V_BP   (V_BP_TB)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .xIn        (xIn),
        .yIn        (yIn),
        .colourIn   (colourIn),
        .plotIn     (plotIn),
        .busy       (busy),
        .dropCount  (dropCount),
        .vgaClk     (vgaClk),
        .vgaR       (vgaR),
        .vgaG       (vgaG),
        .vgaB       (vgaB),
        .vgaHS      (vgaHS),
        .vgaVS      (vgaVS),
        .vgaBlankN  (vgaBlankN),
        .frameStart (frameStart)
    );

    // 100 MHz-style free-running clock, period 10
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Safety net in case something stalls outside the bounded loops
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one Clock and settle just after the edge
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Issue one plot lasting exactly one Clock
    task automatic applyStimulus(input logic [8:0] x, input logic [7:0] y, input logic [5:0] c);
        xIn      = x;
        yIn      = y;
        colourIn = c;
        plotIn   = 1'b1;
        step();
        plotIn   = 1'b0;
    endtask

    // All outputs must sit at their reset values after a sampled Reset
    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"},   busy, 1);
        checkOutput({tag, "_drop"},   dropCount, 0);
        checkOutput({tag, "_vgaclk"}, vgaClk, 0);
        checkOutput({tag, "_rgb"},    {vgaR, vgaG, vgaB}, 0);
        checkOutput({tag, "_hs"},     vgaHS, 1);
        checkOutput({tag, "_vs"},     vgaVS, 1);
        checkOutput({tag, "_blankn"}, vgaBlankN, 0);
        checkOutput({tag, "_fs"},     frameStart, 0);
    endtask

    // Hand-derived picture after the plots below; frame 1 sees the collision write
    function automatic logic [23:0] pixModel(input int frame, input int h, input int v);
        if ((h == 10 || h == 11) && (v == 6 || v == 7)) return 24'hFF0055;
        if ((h == 638 || h == 639) && (v == 6 || v == 7)) return 24'h555555;
        if ((h == 20) && (v == 2)) return (frame == 0) ? 24'h000000 : 24'hAAAAAA;
        if ((h / 2 == 10) && (v / 2 == 1)) return 24'hAAAAAA;
        return 24'h000000;
    endfunction

    initial begin
        int hsTicks;
        int visTicks;
        int vsLines;
        int fsCount;

        Reset    = 1'b1;
        plotIn   = 1'b0;
        xIn      = '0;
        yIn      = '0;
        colourIn = '0;
        step();
        step();
        checkResetState("por");

        // Release reset and time the clear sweep; one plot lands mid-sweep
        Reset = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < CLEAR_CYC + 100) begin
            plotIn = (n == 10);
            n++;
            step();
        end
        plotIn = 1'b0;
        checkOutput("clear_len", n, CLEAR_CYC);
        checkOutput("drop_during_clear", dropCount, 1);

        // Two in-range plots, then three that fall outside the framebuffer
        applyStimulus(9'd5,   8'd3,   6'b110001);
        applyStimulus(9'd319, 8'd3,   6'b010101);
        applyStimulus(9'd320, 8'd0,   6'b111111);
        applyStimulus(9'd0,   8'd240, 6'b111111);
        applyStimulus(9'd0,   8'd4,   6'b111111);
        checkOutput("drop_out_of_range", dropCount, 4);

        // Align to the next frame start
        n = 0;
        while (frameStart !== 1'b1 && n < FRAME_CYC + 100) begin
            n++;
            step();
        end
        checkOutput("wait_frame_start", frameStart, 1);

        // Monitor two full frames; k = 0 is the frameStart cycle
        hsTicks  = 0;
        visTicks = 0;
        vsLines  = 0;
        fsCount  = 0;
        for (int k = 0; k < 2 * FRAME_CYC; k++) begin
            int fk;
            int frame;
            int h;
            int v;
            fk    = k % FRAME_CYC;
            frame = k / FRAME_CYC;
            h     = (fk / 2) % H_TOT;
            v     = (fk / 2) / H_TOT;

            if (fk == 0) begin
                vsLines = 0;
                fsCount = 0;
                checkOutput("frame_start_pos", frameStart, 1);
            end
            if (frameStart === 1'b1) fsCount++;
            if (k < 4) checkOutput("vga_clk_phase", vgaClk, k % 2);

            if (k % 2 == 0) begin
                if (h == 0) begin
                    hsTicks  = 0;
                    visTicks = 0;
                    if (vgaVS === 1'b0) vsLines++;
                end
                if (vgaHS === 1'b0) hsTicks++;
                if (vgaBlankN === 1'b1) visTicks++;
                for (int p = 0; p < NPROBE; p++) begin
                    if (h == PROBE_H[p] && v == PROBE_V[p]) begin
                        checkOutput($sformatf("pix_f%0d_h%0d_v%0d", frame, h, v),
                                    {vgaR, vgaG, vgaB}, pixModel(frame, h, v));
                    end
                end
                if (h == H_TOT - 1) begin
                    checkOutput($sformatf("hs_low_ticks_f%0d_v%0d", frame, v), hsTicks, 96);
                    checkOutput($sformatf("visible_ticks_f%0d_v%0d", frame, v), visTicks,
                                (v < V_VIS_TB) ? 640 : 0);
                end
            end

            if (fk == FRAME_CYC - 1) begin
                checkOutput($sformatf("vs_low_lines_f%0d", frame), vsLines, 2);
                checkOutput($sformatf("frame_starts_f%0d", frame), fsCount, 1);
            end

            // Plot onto framebuffer pixel (10,1) on the very edge that reads it for (20,2)
            if (k == 3238) begin
                xIn      = 9'd10;
                yIn      = 8'd1;
                colourIn = 6'b101010;
                plotIn   = 1'b1;
            end else begin
                plotIn   = 1'b0;
            end
            step();
        end
        checkOutput("frame_period", frameStart, 1);

        // Flood with out-of-range plots until the drop counter pins
        for (int i = 0; i < 300; i++) begin
            applyStimulus(9'd400, 8'd10, 6'b000011);
            if (i == 100) checkOutput("drop_count_mid", dropCount, 105);
        end
        checkOutput("drop_saturate", dropCount, 255);

        // Reset from RUN, then again partway through the resulting clear
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checkResetState("run_reset");
        for (int i = 0; i < CLEAR_CYC / 2; i++) step();
        checkOutput("mid_clear_busy", busy, 1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checkResetState("clear_reset");
        n = 0;
        while (busy === 1'b1 && n < CLEAR_CYC + 100) begin
            if (n < 3) checkOutput($sformatf("restart_fs_%0d", n), frameStart, (n == 2));
            n++;
            step();
        end
        checkOutput("restart_clear_len", n, CLEAR_CYC);
        checkOutput("restart_drop", dropCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
